// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB completer backed by a word-addressed register memory.
// Programmable wait states (latched at setup) and slave-error signalling
// for misaligned or out-of-range addresses. Outputs depend only on
// registered state, so an asynchronous reset clears them immediately.
module apb_slave_mem #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              pclk,
  input  logic              preset_n,
  input  logic              pselx,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [3:0]        wait_cfg_i,
  output logic              pready,
  output logic              pslverr,
  output logic [DATA_W-1:0] prdata
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_L = (ADDR_W-2)'(DEPTH);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [IDX_W-1:0]          addr_q, addr_d;   // word index latched at setup
  logic                      wr_q, wr_d;
  logic                      err_q, err_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;

  // Next-state: setup capture, wait countdown, abort and write commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    err_d   = err_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        // Only a genuine setup phase starts a transfer; a stray
        // access phase without setup is ignored.
        if (pselx && !penable) begin
          addr_d  = paddr[IDX_W+1:2];
          wr_d    = pwrite;
          cnt_d   = wait_cfg_i;
          err_d   = (paddr[1:0] != 2'b00) || (paddr[ADDR_W-1:2] >= DEPTH_L);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;                   // abort: no commit, no response
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = IDLE;
          // pwdata is taken at the completing edge, not at setup
          if (penable && wr_q && !err_q)
            mem_d[addr_q] = pwdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, transfer context and memory; everything clears on reset
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  // Response decoded from registered state only
  always_comb begin
    pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
    pslverr = pready && err_q;
    prdata  = (pready && !wr_q && !err_q) ? mem_q[addr_q] : '0;
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: directed self-checking bench for apb_slave_mem.
module tb_apb_slave_mem;

  logic        pclk = 1'b0;
  logic        preset_n;
  logic        pselx, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  wait_cfg_i;
  logic        pready, pslverr;
  logic [31:0] prdata;

  int n_chk = 0;
  int n_err = 0;

  apb_slave_mem #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
    .pclk(pclk), .preset_n(preset_n), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .wait_cfg_i(wait_cfg_i),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transfer, entered and left at posedge+1. wait_cfg_i is
  // changed to w_late after setup to show it is only sampled at setup.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] w, input logic [3:0] w_late,
                      output logic [31:0] rd, output logic err, output int waits);
    bit done;
    pselx = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    wait_cfg_i = w;
    @(posedge pclk); #1;
    penable = 1'b1; wait_cfg_i = w_late;
    waits = 0; done = 0; rd = '0; err = 1'b0;
    while (!done) begin
      @(negedge pclk);
      if (pready) begin
        rd = prdata; err = pslverr; done = 1;
      end else begin
        waits++;
        if (waits > 20) begin
          chk("xfer_timeout", 32'(waits), 32'd0);
          done = 1;
        end
      end
      @(posedge pclk); #1;
    end
    pselx = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          waits;
  longint      t0;

  initial begin
    preset_n = 1'b0; pselx = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; wait_cfg_i = '0;
    #23;
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_pslverr", 32'(pslverr), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    @(posedge pclk); #1; preset_n = 1'b1;

    // basic write then read, no waits
    xfer(1'b1, 32'h08, 32'hDEADBEEF, 4'd0, 4'd0, rd, err, waits);
    chk("w08_waits", 32'(waits), 32'd0);
    chk("w08_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h08, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("r08_data", rd, 32'hDEADBEEF);
    chk("r08_err", 32'(err), 32'd0);
    chk("r08_waits", 32'(waits), 32'd0);

    // three wait states, unwritten word reads 0
    xfer(1'b0, 32'h04, 32'h0, 4'd3, 4'd3, rd, err, waits);
    chk("r04_waits", 32'(waits), 32'd3);
    chk("r04_data", rd, 32'd0);

    // out-of-range write errors and does not alias into word 0
    xfer(1'b1, 32'h40, 32'h11111111, 4'd0, 4'd0, rd, err, waits);
    chk("w40_err", 32'(err), 32'd1);
    xfer(1'b0, 32'h00, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("r00_data", rd, 32'd0);
    chk("r00_err", 32'(err), 32'd0);

    // misaligned reads error with zero data (0x0A would hit DEADBEEF)
    xfer(1'b0, 32'h06, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("r06_err", 32'(err), 32'd1);
    chk("r06_data", rd, 32'd0);
    xfer(1'b0, 32'h0A, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("r0A_err", 32'(err), 32'd1);
    chk("r0A_data", rd, 32'd0);

    // back-to-back, no idle cycles: 4 transfers x 2 cycles = 80 ns
    t0 = $time;
    xfer(1'b1, 32'h00, 32'hA, 4'd0, 4'd0, rd, err, waits);
    xfer(1'b1, 32'h3C, 32'hB, 4'd0, 4'd0, rd, err, waits);
    chk("b2b_w3C_err", 32'(err), 32'd0);
    xfer(1'b0, 32'h00, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("b2b_r00", rd, 32'hA);
    xfer(1'b0, 32'h3C, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("b2b_r3C", rd, 32'hB);
    chk("b2b_time", 32'($time - t0), 32'd80);

    // reset during a ready read cycle: outputs drop without a clock edge
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h3C; wait_cfg_i = 4'd0;
    @(posedge pclk); #1; penable = 1'b1;
    @(negedge pclk);
    chk("rrst_pre_data", prdata, 32'hB);
    #1 preset_n = 1'b0;
    #1;
    chk("rrst_pready", 32'(pready), 32'd0);
    chk("rrst_prdata", prdata, 32'd0);
    pselx = 1'b0; penable = 1'b0;
    @(posedge pclk); #1; preset_n = 1'b1;
    xfer(1'b0, 32'h3C, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("rrst_mem_cleared", rd, 32'd0);

    // abort after two access cycles: no response, no write
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
    wait_cfg_i = 4'd4;
    @(posedge pclk); #1; penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk); chk("abort_wait_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    pselx = 1'b0; penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk); chk("abort_idle_pready", 32'(pready), 32'd0);
    end
    @(posedge pclk); #1;
    xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("abort_r10", rd, 32'd0);

    // reset pulse in a wait cycle: write lost, fresh setup required after
    xfer(1'b1, 32'h08, 32'h12345678, 4'd0, 4'd0, rd, err, waits);
    pselx = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h55;
    wait_cfg_i = 4'd4;
    @(posedge pclk); #1; penable = 1'b1;
    @(posedge pclk); #1;
    preset_n = 1'b0;
    #1;
    chk("wrst_pready", 32'(pready), 32'd0);
    chk("wrst_pslverr", 32'(pslverr), 32'd0);
    #1 preset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pclk); chk("wrst_nosetup_pready", 32'(pready), 32'd0);
    end
    @(posedge pclk); #1;
    pselx = 1'b0; penable = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("wrst_r10", rd, 32'd0);
    xfer(1'b0, 32'h08, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("wrst_r08_cleared", rd, 32'd0);

    // access phase with no setup: ignored
    pselx = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk); chk("nosetup_pready", 32'(pready), 32'd0);
      @(posedge pclk); #1;
    end
    pselx = 1'b0; penable = 1'b0;
    xfer(1'b0, 32'h10, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("nosetup_r10", rd, 32'd0);

    // wait_cfg_i changed mid-transfer has no effect
    xfer(1'b1, 32'h14, 32'h66, 4'd2, 4'd7, rd, err, waits);
    chk("wcfg_waits", 32'(waits), 32'd2);
    xfer(1'b0, 32'h14, 32'h0, 4'd0, 4'd0, rd, err, waits);
    chk("wcfg_r14", rd, 32'h66);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
